id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus operand-forwarding front end for the ALU.
//  - Latches decoded operands and controls from ID; drives ALU OP1/OP2/sel.
//  - Detects load-use hazards and inserts a one-cycle bubble, holding IF/ID upstream.
//  - Forwards EX/MEM and MEM/WB results so back-to-back dependent ALU ops need no stalls.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/fwd_mux.sv | 27 ++
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, ALU operation codes and immediate sign-extension for the pipeline
package pipeline_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int IMM_W      = 16;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_MUL = 4'd3,
        ALU_DIV = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_SLL = 4'd8
    } alu_sel_e;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: one ALU operand's priority select (EX/MEM result, then MEM/WB data, then register-file data)
module fwd_mux
    import pipeline_pkg::*;
(
    input  logic                  i_en,
    input  logic [REG_ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_reg_data,
    input  logic                  i_mem_we,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic [DATA_W-1:0]     i_mem_res,
    input  logic                  i_wb_we,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [DATA_W-1:0]     i_wb_data,
    output logic [DATA_W-1:0]     o_data
);

    logic w_mem_hit;
    logic w_wb_hit;

    // $0 is hard-wired zero, so a write aimed at it must never be forwarded
    assign w_mem_hit = i_en & i_mem_we & (i_mem_rd != '0) & (i_mem_rd == i_addr);
    assign w_wb_hit  = i_en & i_wb_we  & (i_wb_rd  != '0) & (i_wb_rd  == i_addr);

    // the EX/MEM value is newer than MEM/WB, so it wins when both match
    assign o_data = w_mem_hit ? i_mem_res : w_wb_hit ? i_wb_data : i_reg_data;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and ALU operand forwarding.
// Define IDEX_FWD_EN to enable EX/MEM and MEM/WB forwarding; without it the registered data is used directly.
module id_ex_stage
    import pipeline_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_in,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [IMM_W-1:0]      id_imm,
    input  logic [3:0]            id_alu_sel,
    input  logic                  id_alu_src,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_reg_write,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_res,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     OP1,
    output logic [DATA_W-1:0]     OP2,
    output logic [3:0]            sel,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_reg_write,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic                  id_hold
);

`ifdef IDEX_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [DATA_W-1:0]     r_rs_data;
    logic [DATA_W-1:0]     r_rt_data;
    logic [IMM_W-1:0]      r_imm;
    logic [3:0]            r_sel;
    logic                  r_alu_src;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_reg_write;
    logic                  w_load_use;
    logic                  w_clear;
    logic [DATA_W-1:0]     w_fwd_rs;
    logic [DATA_W-1:0]     w_fwd_rt;

    assign w_load_use = id_valid & r_valid & r_mem_read & (r_rd != '0) & ((r_rd == id_rs) | (r_rd == id_rt));
    assign id_hold    = stall_in | (w_load_use & ~flush);
    // a downstream stall outranks the bubble, so the load stays in EX and the hazard is re-evaluated later
    assign w_clear    = rst | flush | (~stall_in & w_load_use);

    // EX register: clear on reset/flush/bubble, hold on stall, otherwise take ID
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_valid     <= 1'b0;
            r_rd        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_sel       <= '0;
            r_alu_src   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (!stall_in) begin
            r_valid     <= id_valid;
            r_rd        <= id_rd;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_sel       <= id_alu_sel;
            r_alu_src   <= id_alu_src;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
            r_reg_write <= id_reg_write;
        end
    end

    fwd_mux u_fwd_rs (
        .i_en       (FWD_EN),
        .i_addr     (r_rs),
        .i_reg_data (r_rs_data),
        .i_mem_we   (mem_reg_write),
        .i_mem_rd   (mem_rd),
        .i_mem_res  (mem_res),
        .i_wb_we    (wb_reg_write),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_data     (w_fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .i_en       (FWD_EN),
        .i_addr     (r_rt),
        .i_reg_data (r_rt_data),
        .i_mem_we   (mem_reg_write),
        .i_mem_rd   (mem_rd),
        .i_mem_res  (mem_res),
        .i_wb_we    (wb_reg_write),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_data     (w_fwd_rt)
    );

    assign OP1           = w_fwd_rs;
    assign OP2           = r_alu_src ? sext_imm(r_imm) : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign sel           = r_sel;
    assign ex_valid      = r_valid;
    assign ex_rd         = r_rd;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_reg_write  = r_reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic checked against a behavioural EX-stage model
module tb_id_ex_stage;
    import pipeline_pkg::*;

`ifdef IDEX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, stall_in, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd, mem_rd, wb_rd;
    logic [31:0] id_rs_data, id_rt_data, mem_res, wb_data;
    logic [15:0] id_imm;
    logic [3:0]  id_alu_sel;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, mem_reg_write, wb_reg_write;
    logic [31:0] OP1, OP2, ex_store_data;
    logic [3:0]  sel;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, id_hold;
    logic [4:0]  ex_rd;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        v;
        logic [4:0]  rd, rs, rt;
        logic [31:0] rsd, rtd;
        logic [15:0] imm;
        logic [3:0]  sel;
        logic        src, mr, mw, rw;
    } ex_t;

    ex_t m;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_alu_sel(id_alu_sel), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_res(mem_res), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .OP1(OP1), .OP2(OP2), .sel(sel), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_store_data(ex_store_data), .id_hold(id_hold)
    );

    task automatic idle();
        rst = 0; flush = 0; stall_in = 0; id_valid = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_alu_sel = 0; id_alu_src = 0; id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
        mem_reg_write = 0; mem_rd = 0; mem_res = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic issue(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, input logic [15:0] imm,
                         input logic [3:0] s, input logic src, mr, mw, rw);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
        id_imm = imm; id_alu_sel = s; id_alu_src = src; id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] raw);
        if (FWD && a != 0 && mem_reg_write && mem_rd == a) return mem_res;
        if (FWD && a != 0 && wb_reg_write && wb_rd == a) return wb_data;
        return raw;
    endfunction

    task automatic test_reset();
        idle();
        issue(1, 2, 3, 32'h5, 32'h7, 16'h0, ALU_ADD, 0, 1, 1, 1);
        rst = 1;
        tick();
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
        checks++; if (sel !== 4'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", ex_rd); end
        checks++; if ({ex_mem_read, ex_mem_write, ex_reg_write} !== 3'b000)
            begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {ex_mem_read, ex_mem_write, ex_reg_write}); end
        checks++; if (id_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", id_hold); end
        rst = 0;
    endtask

    task automatic test_add();
        idle();
        issue(1, 2, 3, 32'd5, 32'd7, 16'h0, ALU_ADD, 0, 0, 0, 1);
        tick();
        checks++; if (OP1 !== 32'd5) begin errors++; $display("FAIL add_op1 got=%0h exp=5", OP1); end
        checks++; if (OP2 !== 32'd7) begin errors++; $display("FAIL add_op2 got=%0h exp=7", OP2); end
        checks++; if (sel !== 4'd2) begin errors++; $display("FAIL add_sel got=%0d exp=2", sel); end
        checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL add_rd got=%0d exp=3", ex_rd); end
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", ex_valid); end
    endtask

    task automatic test_load_use();
        idle();
        issue(1, 2, 4, 32'h100, 32'h0, 16'h8, ALU_ADD, 1, 1, 0, 1);
        tick();
        checks++; if (ex_mem_read !== 1'b1) begin errors++; $display("FAIL lu_load got=%b exp=1", ex_mem_read); end
        issue(4, 2, 5, 32'h0, 32'h3, 16'h0, ALU_ADD, 0, 0, 0, 1);
        #1;
        checks++; if (id_hold !== 1'b1) begin errors++; $display("FAIL lu_hold got=%b exp=1", id_hold); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
        checks++; if (id_hold !== 1'b0) begin errors++; $display("FAIL lu_hold_release got=%b exp=0", id_hold); end
        tick();
        checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd5})
            begin errors++; $display("FAIL lu_enter got=%b/%0d exp=1/5", ex_valid, ex_rd); end
    endtask

    task automatic test_forward();
        idle();
        issue(6, 7, 8, 32'h11, 32'h22, 16'h0, ALU_ADD, 0, 0, 0, 1);
        mem_reg_write = 1; mem_rd = 6; mem_res = 32'hAA;
        wb_reg_write = 1; wb_rd = 6; wb_data = 32'hBB;
        tick();
        checks++; if (OP1 !== (FWD ? 32'hAA : 32'h11)) begin errors++; $display("FAIL fwd_mem got=%0h exp=%0h", OP1, FWD ? 32'hAA : 32'h11); end
        mem_reg_write = 0;
        #1;
        checks++; if (OP1 !== (FWD ? 32'hBB : 32'h11)) begin errors++; $display("FAIL fwd_wb got=%0h exp=%0h", OP1, FWD ? 32'hBB : 32'h11); end
        mem_reg_write = 1; mem_rd = 7; wb_rd = 7;
        #1;
        checks++; if (ex_store_data !== (FWD ? 32'hAA : 32'h22))
            begin errors++; $display("FAIL fwd_rt got=%0h exp=%0h", ex_store_data, FWD ? 32'hAA : 32'h22); end
        issue(0, 0, 8, 32'h33, 32'h44, 16'h0, ALU_OR, 0, 0, 0, 1);
        mem_rd = 0; wb_rd = 0;
        tick();
        checks++; if ({OP1, OP2} !== {32'h33, 32'h44}) begin errors++; $display("FAIL fwd_r0 got=%0h/%0h exp=33/44", OP1, OP2); end
    endtask

    task automatic test_imm();
        idle();
        issue(1, 9, 2, 32'h1, 32'h1234, 16'hFFFE, ALU_ADD, 1, 0, 1, 0);
        mem_reg_write = 1; mem_rd = 9; mem_res = 32'h55;
        tick();
        checks++; if (OP2 !== 32'hFFFFFFFE) begin errors++; $display("FAIL imm_op2 got=%0h exp=fffffffe", OP2); end
        checks++; if (ex_store_data !== (FWD ? 32'h55 : 32'h1234))
            begin errors++; $display("FAIL imm_store got=%0h exp=%0h", ex_store_data, FWD ? 32'h55 : 32'h1234); end
    endtask

    task automatic test_flush_stall();
        idle();
        issue(1, 2, 4, 32'h0, 32'h0, 16'h0, ALU_ADD, 1, 1, 0, 1);
        tick();
        issue(4, 3, 6, 32'h0, 32'h0, 16'h0, ALU_ADD, 0, 0, 0, 1);
        flush = 1;
        #1;
        checks++; if (id_hold !== 1'b0) begin errors++; $display("FAIL flush_hold got=%b exp=0", id_hold); end
        tick();
        checks++; if ({ex_valid, ex_reg_write, ex_rd} !== 7'd0)
            begin errors++; $display("FAIL flush_bubble got=%b/%b/%0d exp=0/0/0", ex_valid, ex_reg_write, ex_rd); end
        flush = 0;
        issue(1, 2, 7, 32'h10, 32'h20, 16'h0, ALU_XOR, 0, 0, 0, 1);
        tick();
        stall_in = 1;
        issue(3, 3, 9, 32'h99, 32'h98, 16'h0, ALU_SUB, 0, 1, 0, 1);
        #1;
        checks++; if (id_hold !== 1'b1) begin errors++; $display("FAIL stall_hold got=%b exp=1", id_hold); end
        tick();
        checks++; if ({ex_valid, ex_rd, sel, OP1, OP2} !== {1'b1, 5'd7, 4'd5, 32'h10, 32'h20})
            begin errors++; $display("FAIL stall_keep got=%b/%0d/%0d/%0h/%0h exp=1/7/5/10/20", ex_valid, ex_rd, sel, OP1, OP2); end
        stall_in = 0;
    endtask

    task automatic test_random();
        logic lu;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = (i == 0) || ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall_in = ($urandom_range(0, 7) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
            id_alu_sel = 4'($urandom_range(0, 8)); id_alu_src = 1'($urandom);
            id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom); id_reg_write = 1'($urandom);
            mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 3)); mem_res = $urandom;
            wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
            #1;
            lu = id_valid && m.v && m.mr && m.rd != 0 && (m.rd == id_rs || m.rd == id_rt);
            if (i > 0) begin
                checks++;
                if ({ex_valid, ex_rd, ex_mem_read, ex_mem_write, ex_reg_write, id_hold} !==
                    {m.v, m.rd, m.mr, m.mw, m.rw, stall_in || (lu && !flush)})
                    begin errors++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", i,
                        {ex_valid, ex_rd, ex_mem_read, ex_mem_write, ex_reg_write, id_hold},
                        {m.v, m.rd, m.mr, m.mw, m.rw, stall_in || (lu && !flush)}); end
                if (m.v) begin
                    checks++;
                    if ({sel, OP1, OP2, ex_store_data} !==
                        {m.sel, fwd(m.rs, m.rsd), m.src ? 32'($signed(m.imm)) : fwd(m.rt, m.rtd), fwd(m.rt, m.rtd)})
                        begin errors++; $display("FAIL rand_data cyc=%0d got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", i,
                            sel, OP1, OP2, ex_store_data, m.sel, fwd(m.rs, m.rsd),
                            m.src ? 32'($signed(m.imm)) : fwd(m.rt, m.rtd), fwd(m.rt, m.rtd)); end
                end
            end
            @(posedge clk);
            if (rst || flush || (!stall_in && lu))
                m = '{v: 0, rd: 0, rs: 0, rt: 0, rsd: 0, rtd: 0, imm: 0, sel: 0, src: 0, mr: 0, mw: 0, rw: 0};
            else if (!stall_in)
                m = '{v: id_valid, rd: id_rd, rs: id_rs, rt: id_rt, rsd: id_rs_data, rtd: id_rt_data, imm: id_imm,
                      sel: id_alu_sel, src: id_alu_src, mr: id_mem_read, mw: id_mem_write, rw: id_reg_write};
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_add();
        test_load_use();
        test_forward();
        test_imm();
        test_flush_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
